// File: rtl/aes_pkg.sv
// aes_pkg: widths and arbiter state encoding shared by the decipher arbiter files
package aes_pkg;
   localparam int AES_BLOCK_W = 128;
   localparam int AES_KEY_W   = 128;
   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_CORE,
      RESPOND
   } arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner search starting just above ptr
module rr_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx,
   output logic         any
);
   int j;
   always_comb begin
      idx = '0;
      j   = 0;
      // scan farthest-first so the nearest requester above ptr overwrites last
      for (int k = N; k >= 1; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) idx = W'(j);
      end
      any    = |req;
      onehot = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/decipher_arbiter.sv
// decipher_arbiter: round-robin sharing of one AES-128 decipher core among NUM_REQ requesters,
// with a watchdog that answers with an error response if the core never completes.
module decipher_arbiter
   import aes_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IW            = $clog2(NUM_REQ),
   localparam int TW            = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic [NUM_REQ-1:0]             req_valid_in,
   output logic [NUM_REQ-1:0]             req_ready_out,
   input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_block_in,
   input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key_in,
   output logic [NUM_REQ-1:0]             resp_valid_out,
   input  logic [NUM_REQ-1:0]             resp_ready_in,
   output logic [AES_BLOCK_W-1:0]         resp_block_out,
   output logic                           resp_err_out,
   output logic                           core_start_out,
   output logic [AES_BLOCK_W-1:0]         core_block_out,
   output logic [AES_KEY_W-1:0]           core_key_out,
   input  logic [AES_BLOCK_W-1:0]         core_block_in,
   input  logic                           core_complete_in,
   output logic                           busy_out,
   output logic [IW-1:0]                  grant_id_out
);
   arb_state_t             state;
   arb_state_t             next_state;
   logic [IW-1:0]          ptr;
   logic [IW-1:0]          id;
   logic [IW-1:0]          pick_idx;
   logic [NUM_REQ-1:0]     pick_oh;
   logic                   pick_any;
   logic                   accept;
   logic                   done;
   logic                   expired;
   logic [TW-1:0]          timer;
   logic [AES_BLOCK_W-1:0] blk;
   logic [AES_BLOCK_W-1:0] res;
   logic [AES_KEY_W-1:0]   key;
   logic                   err;

   rr_picker #(.N(NUM_REQ), .W(IW)) u_pick (
      .req    (req_valid_in),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign accept  = state == IDLE && pick_any;
   assign done    = state == WAIT_CORE && core_complete_in;
   assign expired = state == WAIT_CORE && timer == TW'(TIMEOUT_CYCLES - 1);

   always_comb begin
      next_state     = state;
      req_ready_out  = '0;
      resp_valid_out = '0;
      core_start_out = 1'b0;
      resp_err_out   = 1'b0;
      busy_out       = state != IDLE;
      case (state)
         IDLE: begin
            req_ready_out = pick_oh;
            next_state    = accept ? ISSUE : IDLE;
         end
         ISSUE: begin
            core_start_out = 1'b1;
            next_state     = WAIT_CORE;
         end
         WAIT_CORE: next_state = (done || expired) ? RESPOND : WAIT_CORE;
         RESPOND: begin
            resp_valid_out = NUM_REQ'(1) << id;
            resp_err_out   = err;
            next_state     = resp_ready_in[id] ? IDLE : RESPOND;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
         ptr   <= IW'(NUM_REQ - 1);
         id    <= '0;
         timer <= '0;
         blk   <= '0;
         key   <= '0;
         res   <= '0;
         err   <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            blk <= req_block_in[AES_BLOCK_W*int'(pick_idx) +: AES_BLOCK_W];
            key <= req_key_in[AES_KEY_W*int'(pick_idx) +: AES_KEY_W];
            id  <= pick_idx;
            ptr <= pick_idx;
         end
         if (state == ISSUE) timer <= '0;
         else if (state == WAIT_CORE) timer <= timer + TW'(1);
         // a completion arriving on the last watchdog cycle still wins
         if (done) begin
            res <= core_block_in;
            err <= 1'b0;
         end else if (expired) begin
            res <= '0;
            err <= 1'b1;
         end
      end
   end

   assign resp_block_out = res;
   assign core_block_out = blk;
   assign core_key_out   = key;
   assign grant_id_out   = id;
endmodule

// File: tb/tb_decipher_arbiter.sv
// tb_decipher_arbiter: scoreboard bench for decipher_arbiter driving a behavioural
// decipher core with fixed latency and the FIPS-197 C.1 vector
`timescale 1ns/1ps
module tb_decipher_arbiter;
   import aes_pkg::*;
   localparam int N   = 4;
   localparam int TO  = 64;
   localparam int LAT = 40;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   typedef struct {
      int           id;
      logic [127:0] blk;
      logic         err;
   } exp_t;

   logic           clk_in           = 1'b0;
   logic           rst_n_in         = 1'b0;
   logic [N-1:0]   req_valid_in     = '0;
   logic [N-1:0]   resp_ready_in    = '1;
   logic [N*128-1:0] req_block_in   = '0;
   logic [N*128-1:0] req_key_in     = '0;
   logic [127:0]   core_block_in    = '0;
   logic           core_complete_in = 1'b0;
   logic [N-1:0]   req_ready_out;
   logic [N-1:0]   resp_valid_out;
   logic [127:0]   resp_block_out;
   logic           resp_err_out;
   logic           core_start_out;
   logic [127:0]   core_block_out;
   logic [127:0]   core_key_out;
   logic           busy_out;
   logic [1:0]     grant_id_out;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, n_start = 0, n_resp = 0, start_cyc = 0, rv_cyc = 0;
   int core_lat = LAT;
   bit exp_to = 1'b0, late_req = 1'b0, prev_rv = 1'b0;
   logic [127:0] last_blk = '0;
   logic         last_err = 1'b0;
   logic [N-1:0] last_rv  = '0;
   exp_t sb[$];
   int   grants[$];

   decipher_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .req_valid_in     (req_valid_in),
      .req_ready_out    (req_ready_out),
      .req_block_in     (req_block_in),
      .req_key_in       (req_key_in),
      .resp_valid_out   (resp_valid_out),
      .resp_ready_in    (resp_ready_in),
      .resp_block_out   (resp_block_out),
      .resp_err_out     (resp_err_out),
      .core_start_out   (core_start_out),
      .core_block_out   (core_block_out),
      .core_key_out     (core_key_out),
      .core_block_in    (core_block_in),
      .core_complete_in (core_complete_in),
      .busy_out         (busy_out),
      .grant_id_out     (grant_id_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // the C.1 vector deciphers to its plaintext; any other job gets a fixed scramble
   function automatic logic [127:0] ref_dec(input logic [127:0] b, input logic [127:0] k);
      return (b == C1_CT && k == C1_KEY) ? C1_PT
                                         : b ^ {k[63:0], k[127:64]} ^ {4{32'h5a3c_96e1}};
   endfunction

   // behavioural core: latches its inputs on start, completes core_lat cycles later (0 = never)
   initial begin : core_model
      int cnt;
      logic [127:0] pending;
      cnt     = 0;
      pending = '0;
      forever begin
         @(negedge clk_in);
         core_complete_in = 1'b0;
         if (late_req) begin
            core_complete_in = 1'b1;
            core_block_in    = {4{32'hbad0_0bad}};
            late_req         = 1'b0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               core_complete_in = 1'b1;
               core_block_in    = pending;
            end
         end
         if (core_start_out) begin
            n_start++;
            if (core_lat > 0) begin
               cnt     = core_lat;
               pending = ref_dec(core_block_out, core_key_out);
            end
         end
      end
   end

   initial begin : monitor
      int   id;
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (rst_n_in) begin
            cyc++;
            if (core_start_out) start_cyc = cyc;
            if (resp_valid_out != '0 && !prev_rv) rv_cyc = cyc;
            prev_rv = resp_valid_out != '0;
            if (req_ready_out != '0) begin
               id = 0;
               for (int i = 0; i < N; i++) if (req_ready_out[i]) id = i;
               chk("rdy_onehot", 128'($onehot(req_ready_out)), 128'd1);
               chk("rdy_valid", 128'(req_ready_out & ~req_valid_in), 128'd0);
               grants.push_back(id);
               e.id  = id;
               e.err = exp_to;
               e.blk = exp_to ? '0 : ref_dec(req_block_in[128*id +: 128], req_key_in[128*id +: 128]);
               sb.push_back(e);
            end
            if (resp_valid_out != '0) begin
               chk("resp_onehot", 128'($onehot(resp_valid_out)), 128'd1);
               if ((resp_valid_out & resp_ready_in) != '0) begin
                  chk("no_acc_exit", 128'(req_ready_out), 128'd0);
                  last_rv  = resp_valid_out;
                  last_blk = resp_block_out;
                  last_err = resp_err_out;
                  n_resp++;
                  if (sb.size() == 0) chk("resp_spurious", 128'(resp_valid_out), 128'd0);
                  else begin
                     e = sb.pop_front();
                     chk("resp_id", 128'(resp_valid_out), 128'(1) << e.id);
                     chk("resp_blk", resp_block_out, e.blk);
                     chk("resp_err", 128'(resp_err_out), 128'(e.err));
                  end
               end
            end
         end
      end
   end

   task automatic drive(input int i, input logic [127:0] b, input logic [127:0] k);
      @(posedge clk_in);
      #1;
      req_block_in[128*i +: 128] = b;
      req_key_in[128*i +: 128]   = k;
      req_valid_in[i]            = 1'b1;
   endtask

   task automatic wait_acc(input int i);
      int t;
      t = 0;
      do begin
         @(negedge clk_in);
         t++;
      end while (!req_ready_out[i] && t < 300);
      chk($sformatf("accept_%0d", i), 128'(req_ready_out[i]), 128'd1);
      @(posedge clk_in);
      #1;
      req_valid_in[i] = 1'b0;
   endtask

   task automatic send(input int i, input logic [127:0] b, input logic [127:0] k);
      drive(i, b, k);
      wait_acc(i);
   endtask

   task automatic wait_idle(input int bound);
      int t;
      t = 0;
      do begin
         @(negedge clk_in);
         t++;
      end while (busy_out && t < bound);
      chk("idle", 128'(busy_out), 128'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin : main
      int s0, r0, t;
      int order[5];
      bit bad;
      logic [127:0] held;
      order = '{0, 1, 2, 3, 0};
      repeat (3) @(negedge clk_in);
      chk("rst_busy", 128'(busy_out), 128'd0);
      chk("rst_ready", 128'(req_ready_out), 128'd0);
      chk("rst_rvalid", 128'(resp_valid_out), 128'd0);
      chk("rst_start", 128'(core_start_out), 128'd0);
      chk("rst_cblk", core_block_out, 128'd0);
      chk("rst_ckey", core_key_out, 128'd0);
      chk("rst_rblk", resp_block_out, 128'd0);
      chk("rst_err", 128'(resp_err_out), 128'd0);
      chk("rst_gid", 128'(grant_id_out), 128'd0);
      rst_n_in = 1'b1;
      // all requesters valid together from reset
      grants.delete();
      s0 = n_start;
      r0 = n_resp;
      @(posedge clk_in);
      #1;
      for (int i = 0; i < N; i++) begin
         req_block_in[128*i +: 128] = {4{32'hc0de_0000 + 32'(i)}};
         req_key_in[128*i +: 128]   = {4{32'h0bad_1000 + 32'(i)}};
      end
      req_valid_in = '1;
      t = 0;
      while (grants.size() < 5 && t < 600) begin
         @(negedge clk_in);
         t++;
      end
      chk("rr_accepts", 128'(grants.size() >= 5), 128'd1);
      @(posedge clk_in);
      #1;
      req_valid_in = '0;
      wait_idle(200);
      for (int i = 0; i < 5; i++)
         chk($sformatf("rr_order_%0d", i), 128'(i < grants.size() ? grants[i] : -1), 128'(order[i]));
      chk("rr_starts", 128'(n_start - s0), 128'd5);
      chk("rr_resps", 128'(n_resp - r0), 128'd5);
      // single FIPS-197 C.1 job on requester 2
      s0 = n_start;
      r0 = n_resp;
      send(2, C1_CT, C1_KEY);
      wait_idle(200);
      chk("fips_starts", 128'(n_start - s0), 128'd1);
      chk("fips_resps", 128'(n_resp - r0), 128'd1);
      chk("fips_rvalid", 128'(last_rv), 128'b0100);
      chk("fips_pt", last_blk, C1_PT);
      chk("fips_err", 128'(last_err), 128'd0);
      chk("fips_latency", 128'(rv_cyc - start_cyc), 128'(LAT + 1));
      // response back-pressure on requester 1 while requester 0 waits
      resp_ready_in = 4'b1101;
      s0 = n_start;
      r0 = n_resp;
      send(1, {4{32'h1357_9bdf}}, {4{32'h2468_ace0}});
      t = 0;
      while (!resp_valid_out[1] && t < 100) begin
         @(negedge clk_in);
         t++;
      end
      held = resp_block_out;
      chk("stall_blk", held, ref_dec({4{32'h1357_9bdf}}, {4{32'h2468_ace0}}));
      drive(0, {4{32'h0f0f_3c3c}}, {4{32'h7777_1111}});
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk_in);
         bad |= resp_block_out !== held || req_ready_out != '0 || resp_valid_out != 4'b0010;
      end
      chk("stall_stable", 128'(bad), 128'd0);
      chk("stall_starts", 128'(n_start - s0), 128'd1);
      @(posedge clk_in);
      #1;
      resp_ready_in = '1;
      wait_acc(0);
      wait_idle(200);
      chk("stall_resps", 128'(n_resp - r0), 128'd2);
      // core never completes, then a late pulse arrives
      core_lat = 0;
      exp_to   = 1'b1;
      send(3, {4{32'h4444_5555}}, {4{32'h6666_7777}});
      wait_idle(300);
      exp_to = 1'b0;
      chk("to_wait", 128'(rv_cyc - start_cyc - 1), 128'(TO));
      chk("to_err", 128'(last_err), 128'd1);
      chk("to_blk", last_blk, 128'd0);
      r0       = n_resp;
      late_req = 1'b1;
      bad      = 1'b0;
      repeat (8) begin
         @(negedge clk_in);
         bad |= busy_out || resp_valid_out != '0;
      end
      chk("late_ignored", 128'(bad), 128'd0);
      chk("late_resps", 128'(n_resp - r0), 128'd0);
      // completion on the last watchdog cycle
      core_lat = TO;
      send(1, {4{32'h9999_aaaa}}, {4{32'hbbbb_cccc}});
      wait_idle(300);
      core_lat = LAT;
      chk("both_err", 128'(last_err), 128'd0);
      chk("both_blk", last_blk, ref_dec({4{32'h9999_aaaa}}, {4{32'hbbbb_cccc}}));
      chk("both_latency", 128'(rv_cyc - start_cyc), 128'(TO + 1));
      // asynchronous reset while waiting on the core
      send(3, {4{32'hdead_beef}}, {4{32'hfeed_face}});
      repeat (10) @(negedge clk_in);
      #2;
      rst_n_in = 1'b0;
      #1;
      chk("arst_busy", 128'(busy_out), 128'd0);
      chk("arst_start", 128'(core_start_out), 128'd0);
      chk("arst_rvalid", 128'(resp_valid_out), 128'd0);
      chk("arst_cblk", core_block_out, 128'd0);
      chk("arst_ckey", core_key_out, 128'd0);
      chk("arst_gid", 128'(grant_id_out), 128'd0);
      sb.delete();
      prev_rv = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      r0  = n_resp;
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk_in);
         bad |= busy_out || resp_valid_out != '0;
      end
      chk("stale_ignored", 128'(bad), 128'd0);
      send(2, C1_CT, C1_KEY);
      wait_idle(200);
      chk("post_rst_resps", 128'(n_resp - r0), 128'd1);
      chk("post_rst_rvalid", 128'(last_rv), 128'b0100);
      chk("post_rst_pt", last_blk, C1_PT);
      chk("sb_empty", 128'(sb.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
